// File: rtl/cla_seq_addsub_pkg.sv
// Shared encodings for the nibble-serial add/subtract unit.
package cla_seq_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_seq_addsub_cla_4.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0]  = c_in;
    assign c[1]  = g[0] | (p[0] & c_in);
    assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;

endmodule

// File: rtl/cla_seq_addsub.sv
// Multi-cycle add/subtract: one shared cla_4 slice walks the operands a nibble
// per cycle, LSB first, with the carry held in a register between nibbles.
module cla_seq_addsub
    import cla_seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    state_t           st, st_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [3:0]       s;
    logic             s_co;
    logic [WIDTH-1:0] res_upd;
    logic             accept;
    logic             last;

    assign ready  = (st == ST_IDLE) || (st == ST_DONE);
    assign done   = (st == ST_DONE);
    assign accept = start & ready;
    assign last   = (cnt == CNT_LAST);

    cla_4 u_cla (
        .a     (a_reg[{cnt, 2'b00} +: 4]),
        .b     (b_reg[{cnt, 2'b00} +: 4]),
        .c_in  (carry),
        .s     (s),
        .c_out (s_co)
    );

    // Result with the current nibble merged in, so zero sees the final value.
    always_comb begin
        res_upd = result;
        res_upd[{cnt, 2'b00} +: 4] = s;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: if (start) st_nxt = ST_RUN;
            ST_RUN:  if (last)  st_nxt = ST_DONE;
            ST_DONE: st_nxt = start ? ST_RUN : ST_IDLE;
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1: the +1 rides in on the initial carry.
            a_reg  <= a;
            b_reg  <= (op_sub == OP_SUB) ? ~b : b;
            carry  <= (op_sub == OP_SUB);
            cnt    <= '0;
            result <= '0;
        end else if (st == ST_RUN) begin
            result <= res_upd;
            carry  <= s_co;
            cnt    <= last ? '0 : cnt + 1'b1;
            if (last) begin
                c_out    <= s_co;
                overflow <= (a_reg[WIDTH-1] ~^ b_reg[WIDTH-1]) & (s[3] ^ a_reg[WIDTH-1]);
                zero     <= (res_upd == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_seq_addsub.sv
// Directed bench for cla_seq_addsub at WIDTH=16.
module tb_cla_seq_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [15:0] a, b;
    logic        ready, done;
    logic [15:0] result;
    logic        c_out, overflow, zero;

    int checks   = 0;
    int failures = 0;

    cla_seq_addsub #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for done, counting negedges from the cycle start was presented.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
        end while (!done && lat < 20);
    endtask

    task automatic op_chk(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic sub, input logic [15:0] er, input logic ec,
                          input logic ev, input logic ez);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; op_sub = sub; start = 1'b1;
        wait_done(lat);
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_res"}, result, er);
        chk({tag, "_cout"}, c_out, ec);
        chk({tag, "_ovf"}, overflow, ev);
        chk({tag, "_zero"}, zero, ez);
    endtask

    initial begin
        int lat;
        int pulses;
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_res", result, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_zero", zero, 0);
        rst_n = 1'b1;

        op_chk("add_basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        op_chk("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        op_chk("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op_chk("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op_chk("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op_chk("sub_equal",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // start held through RUN with changing operands must be ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; op_sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 16'hA5A5 + 16'(i); b = 16'h0F0F; op_sub = i[0];
            chk("ign_ready", ready, 0);
        end
        @(negedge clk);
        chk("ign_done", done, 1);
        chk("ign_res", result, 16'h5555);
        chk("ign_cout", c_out, 0);
        // Back-to-back: accept in the DONE cycle.
        a = 16'h0FF0; b = 16'h0011; op_sub = 1'b0; start = 1'b1;
        wait_done(lat);
        chk("b2b_lat", lat, 5);
        chk("b2b_res", result, 16'h1001);
        chk("b2b_zero", zero, 0);

        // Leave nonzero flags behind, then reset during the second RUN cycle.
        op_chk("pre_rst", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_res", result, 16'h0005);
        rst_n = 1'b0;
        #1;
        chk("mr_ready", ready, 1);
        chk("mr_done", done, 0);
        chk("mr_res", result, 0);
        chk("mr_cout", c_out, 0);
        chk("mr_ovf", overflow, 0);
        chk("mr_zero", zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("mr_no_done", pulses, 0);
        op_chk("post_rst", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
